// File: rtl/pcs_rx_sync.sv
// ---------------------------------------------------------------------------
// pcs_rx_sync
// 1000BASE-X PCS receive code-group synchronization.
//
// Takes aligned 10-bit code groups (one per clock) and decides whether the
// receiver is in code-group sync. It also tracks the even/odd parity of each
// group and passes the group on, one cycle later, together with its parity
// and sync qualification.
//
// Ports
//   clk              in   single clock, one code group per rising edge
//   RESET            in   synchronous active-high reset
//   rx_code_group    in   [9:0] aligned code group (bit9 = a ... bit0 = j)
//   cg_invalid       in   group is not a legal 8B/10B code group
//   cg_is_k          in   group is a special (K) code group
//   signal_detect    in   PMD signal present; low forces loss of sync
//   code_sync_status out  1 = synchronized
//   rx_even          out  parity of the group currently on sync_code_group
//   sync_code_group  out  [9:0] rx_code_group delayed by one cycle
//   sync_valid       out  sync_code_group is qualified by code_sync_status
//
// Build option SYNC_DEBUG_EN (macro) adds:
//   sync_state       out  [1:0] 0=LOSS 1=CDET 2=ACQ 3=SYNC
//   loss_count       out  [7:0] saturating count of SYNC -> LOSS transitions
// ---------------------------------------------------------------------------
module pcs_rx_sync #(
    parameter int COMMA_ACQ = 3,   // commas needed to gain sync
    parameter int BAD_LIMIT = 3,   // net bad groups tolerated while in sync
    parameter int GOOD_RUN  = 4    // good run length that forgives one bad
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [9:0] rx_code_group,
    input  logic       cg_invalid,
    input  logic       cg_is_k,
    input  logic       signal_detect,
    output logic       code_sync_status,
    output logic       rx_even,
    output logic [9:0] sync_code_group,
    output logic       sync_valid
`ifdef SYNC_DEBUG_EN
    ,
    output logic [1:0] sync_state,
    output logic [7:0] loss_count
`endif
);

    localparam int CW = $clog2(COMMA_ACQ + 1);
    localparam int BW = $clog2(BAD_LIMIT + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);

    typedef enum logic [1:0] {
        ST_LOSS = 2'd0,
        ST_CDET = 2'd1,
        ST_ACQ  = 2'd2,
        ST_SYNC = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_comma_cnt;
    logic [CW-1:0]   w_comma_cnt_next;
    logic [BW-1:0]   r_bad_cnt;
    logic [BW-1:0]   w_bad_cnt_next;
    logic [GW-1:0]   r_good_cnt;
    logic [GW-1:0]   w_good_cnt_next;
    logic            r_even;
    logic            w_even_next;
    logic            r_status;
    logic            r_valid;
    logic [9:0]      r_sync_cg;

    logic            w_comma;
    logic            w_is_data;
    logic            w_cgbad;

    assign w_comma   = (rx_code_group[9:3] == 7'b0011111) ||
                       (rx_code_group[9:3] == 7'b1100000);
    assign w_is_data = !cg_is_k && !cg_invalid;

    // r_even is the parity of the previous group, i.e. the parity register
    // value before this edge updates it. A comma is bad when the previous
    // group was even, because the comma itself would then land on an odd
    // slot.
    assign w_cgbad   = cg_invalid || (w_comma && r_even);

    always_comb begin
        w_state_next     = r_state;
        w_comma_cnt_next = r_comma_cnt;
        w_bad_cnt_next   = r_bad_cnt;
        w_good_cnt_next  = r_good_cnt;
        w_even_next      = !r_even;

        if (!signal_detect) begin
            w_state_next     = ST_LOSS;
            w_comma_cnt_next = '0;
            w_bad_cnt_next   = '0;
            w_good_cnt_next  = '0;
        end else begin
            case (r_state)
                ST_LOSS: begin
                    w_comma_cnt_next = '0;
                    if (w_comma) begin
                        w_state_next     = ST_CDET;
                        w_comma_cnt_next = CW'(1);
                        w_even_next      = 1'b1;
                    end
                end

                ST_CDET: begin
                    if (w_is_data) begin
                        if (r_comma_cnt == CW'(COMMA_ACQ)) begin
                            w_state_next    = ST_SYNC;
                            w_bad_cnt_next  = '0;
                            w_good_cnt_next = '0;
                        end else begin
                            w_state_next = ST_ACQ;
                        end
                    end else begin
                        w_state_next     = ST_LOSS;
                        w_comma_cnt_next = '0;
                    end
                end

                ST_ACQ: begin
                    if (w_cgbad) begin
                        w_state_next     = ST_LOSS;
                        w_comma_cnt_next = '0;
                    end else if (w_comma) begin
                        w_state_next     = ST_CDET;
                        w_comma_cnt_next = r_comma_cnt + CW'(1);
                        w_even_next      = 1'b1;
                    end
                end

                ST_SYNC: begin
                    if (w_cgbad) begin
                        if (r_bad_cnt == BW'(BAD_LIMIT)) begin
                            w_state_next     = ST_LOSS;
                            w_comma_cnt_next = '0;
                            w_bad_cnt_next   = '0;
                            w_good_cnt_next  = '0;
                        end else begin
                            w_bad_cnt_next  = r_bad_cnt + BW'(1);
                            w_good_cnt_next = '0;
                        end
                    end else if (r_bad_cnt != '0) begin
                        // A full good run forgives one earlier bad group.
                        if (r_good_cnt == GW'(GOOD_RUN - 1)) begin
                            w_bad_cnt_next  = r_bad_cnt - BW'(1);
                            w_good_cnt_next = '0;
                        end else begin
                            w_good_cnt_next = r_good_cnt + GW'(1);
                        end
                    end
                end

                default: begin
                    w_state_next     = ST_LOSS;
                    w_comma_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state     <= ST_LOSS;
            r_comma_cnt <= '0;
            r_bad_cnt   <= '0;
            r_good_cnt  <= '0;
            r_even      <= 1'b0;
            r_status    <= 1'b0;
            r_valid     <= 1'b0;
            r_sync_cg   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_comma_cnt <= w_comma_cnt_next;
            r_bad_cnt   <= w_bad_cnt_next;
            r_good_cnt  <= w_good_cnt_next;
            r_even      <= w_even_next;
            // Status follows the state chosen for this group, so a falling
            // status appears right after the edge that sampled the bad group.
            r_status    <= (w_state_next == ST_SYNC);
            r_valid     <= (w_state_next == ST_SYNC);
            r_sync_cg   <= rx_code_group;
        end
    end

    assign code_sync_status = r_status;
    assign rx_even          = r_even;
    assign sync_code_group  = r_sync_cg;
    assign sync_valid       = r_valid;

`ifdef SYNC_DEBUG_EN
    logic [7:0] r_loss_count;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_loss_count <= '0;
        end else if ((r_state == ST_SYNC) && (w_state_next == ST_LOSS) &&
                     (r_loss_count != 8'hFF)) begin
            r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign sync_state = r_state;
    assign loss_count = r_loss_count;
`endif

endmodule
